// File: rtl/mem_loader_pkg.sv
// rtl/mem_loader_pkg.sv - shared types and helpers for mem_loader (feature macro MEM_LOADER_VERIFY_EN)
package mem_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_CSUM    = 3'd3,
    S_VERIFY  = 3'd4,
    S_CHECK   = 3'd5
  } state_e;

  function automatic int bytes_of(input int data_size);
    return data_size / BYTE_W;
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// rtl/mem_loader_if.sv - byte stream and memory write port bundle for mem_loader
interface mem_loader_if
  import mem_loader_pkg::*;
#(
  parameter int DATA_SIZE  = 16,
  parameter int ADDR_SIZE  = 8,
  parameter int INSTR_SIZE = 24
);

  logic [BYTE_W-1:0]     rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_SIZE-1:0]  current_addr;
  logic [DATA_SIZE-1:0]  in_data;
  logic                  write_en;
  logic                  execute;
  logic [INSTR_SIZE-1:0] out_data;

  modport master (
    input  rx_data,
    input  rx_valid,
    input  out_data,
    output rx_ready,
    output current_addr,
    output in_data,
    output write_en,
    output execute
  );

  modport slave (
    output rx_data,
    output rx_valid,
    output out_data,
    input  rx_ready,
    input  current_addr,
    input  in_data,
    input  write_en,
    input  execute
  );

endinterface

// File: rtl/mem_loader_byte_assembler.sv
// rtl/mem_loader_byte_assembler.sv - packs little-endian bytes into one DATA_SIZE-bit word
module byte_assembler
  import mem_loader_pkg::*;
#(
  parameter int DATA_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 byte_valid,
  input  logic [BYTE_W-1:0]    byte_in,
  output logic [DATA_SIZE-1:0] word,
  output logic                 word_complete
);

  localparam int BYTES = bytes_of(DATA_SIZE);
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] word_q, word_d;

  always_comb begin
    cnt_d         = cnt_q;
    word_d        = word_q;
    word_complete = 1'b0;
    if (clear) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (byte_valid) begin
      for (int i = 0; i < BYTES; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          word_d[BYTE_W*i +: BYTE_W] = byte_in;
        end
      end
      if (cnt_q == CNT_W'(BYTES - 1)) begin
        cnt_d         = '0;
        word_complete = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte-stream program loader for the instruction memory; MEM_LOADER_VERIFY_EN adds checksum read-back
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int INSTR_SIZE   = 24,
  parameter int DATA_SIZE    = 16,
  parameter int ADDR_SIZE    = 8,
  parameter int PROGRAM_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  mem_loader_if.master         bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_SIZE:0]   words_written
);

  localparam logic [2:0] IDLE    = S_IDLE;
  localparam logic [2:0] COLLECT = S_COLLECT;
  localparam logic [2:0] WRITE   = S_WRITE;
`ifdef MEM_LOADER_VERIFY_EN
  localparam logic [2:0] CSUM    = S_CSUM;
  localparam logic [2:0] VERIFY  = S_VERIFY;
  localparam logic [2:0] CHECK   = S_CHECK;
`endif

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(PROGRAM_SIZE - 1);
  localparam logic [ADDR_SIZE:0]   LAST_WORD = (ADDR_SIZE + 1)'(PROGRAM_SIZE - 1);

  logic [2:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE:0]   words_q, words_d;
  logic                 done_q, done_d;

  logic                 rx_ready;
  logic                 wr_pulse;
  logic                 asm_clear;
  logic                 asm_valid;
  logic                 word_complete;
  logic [DATA_SIZE-1:0] asm_word;

`ifdef MEM_LOADER_VERIFY_EN
  logic [DATA_SIZE-1:0] sum_q, sum_d;
  logic                 mism_q, mism_d;
  logic                 error_q, error_d;
`endif

  // The same assembler collects payload words and, afterwards, the checksum trailer.
`ifdef MEM_LOADER_VERIFY_EN
  assign rx_ready = (state_q == COLLECT) || (state_q == CSUM);
`else
  assign rx_ready = (state_q == COLLECT);
`endif
  assign asm_valid = bus.rx_valid & rx_ready;

  byte_assembler #(
    .DATA_SIZE(DATA_SIZE)
  ) u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (asm_clear),
    .byte_valid   (asm_valid),
    .byte_in      (bus.rx_data),
    .word         (asm_word),
    .word_complete(word_complete)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    words_d   = words_q;
    done_d    = done_q;
    asm_clear = 1'b0;
    wr_pulse  = 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
    sum_d     = sum_q;
    mism_d    = mism_q;
    error_d   = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COLLECT;
          addr_d    = '0;
          words_d   = '0;
          done_d    = 1'b0;
          asm_clear = 1'b1;
`ifdef MEM_LOADER_VERIFY_EN
          error_d   = 1'b0;
`endif
        end
      end
      COLLECT: begin
        if (word_complete) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_pulse = 1'b1;
        words_d  = words_q + (ADDR_SIZE + 1)'(1);
        if (words_q == LAST_WORD) begin
`ifdef MEM_LOADER_VERIFY_EN
          state_d = CSUM;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          addr_d  = addr_q + ADDR_SIZE'(1);
          state_d = COLLECT;
        end
      end
`ifdef MEM_LOADER_VERIFY_EN
      CSUM: begin
        if (word_complete) begin
          state_d = VERIFY;
          addr_d  = '0;
          sum_d   = '0;
          mism_d  = 1'b0;
        end
      end
      VERIFY: begin
        // Any bit above the payload must read back zero since the memory zero-extends.
        sum_d  = sum_q + bus.out_data[DATA_SIZE-1:0];
        mism_d = mism_q | (|bus.out_data[INSTR_SIZE-1:DATA_SIZE]);
        if (addr_q == LAST_ADDR) begin
          state_d = CHECK;
        end else begin
          addr_d = addr_q + ADDR_SIZE'(1);
        end
      end
      CHECK: begin
        error_d = (sum_q != asm_word) | mism_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      words_q <= '0;
      done_q  <= 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
      sum_q   <= '0;
      mism_q  <= 1'b0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      done_q  <= done_d;
`ifdef MEM_LOADER_VERIFY_EN
      sum_q   <= sum_d;
      mism_q  <= mism_d;
      error_q <= error_d;
`endif
    end
  end

`ifdef MEM_LOADER_VERIFY_EN
  assign error = error_q;
`else
  logic [INSTR_SIZE-1:0] unused_rd_word;
  assign unused_rd_word = bus.out_data;
  assign error          = 1'b0;
`endif

  assign bus.rx_ready     = rx_ready;
  assign bus.current_addr = addr_q;
  assign bus.in_data      = asm_word;
  assign bus.write_en     = wr_pulse;
  assign bus.execute      = wr_pulse;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign words_written    = words_q;

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - directed self-checking bench for mem_loader (honours MEM_LOADER_VERIFY_EN)
module tb_mem_loader;

  localparam int INSTR_SIZE   = 24;
  localparam int DATA_SIZE    = 16;
  localparam int ADDR_SIZE    = 4;
  localparam int PROGRAM_SIZE = 3;
`ifdef MEM_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [ADDR_SIZE:0]   words_written;
  logic                 mem_clear;

  mem_loader_if #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE), .INSTR_SIZE(INSTR_SIZE)) bus ();

  mem_loader #(
    .INSTR_SIZE  (INSTR_SIZE),
    .DATA_SIZE   (DATA_SIZE),
    .ADDR_SIZE   (ADDR_SIZE),
    .PROGRAM_SIZE(PROGRAM_SIZE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_written(words_written)
  );

  logic [INSTR_SIZE-1:0] mem [0:(1<<ADDR_SIZE)-1];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < (1 << ADDR_SIZE); i++) mem[i] <= '0;
    end else if (bus.write_en && bus.execute) begin
      mem[bus.current_addr] <= {{(INSTR_SIZE-DATA_SIZE){1'b0}}, bus.in_data};
    end
  end
  assign bus.out_data = mem[bus.current_addr];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  logic [7:0]           stim [0:5];
  logic [DATA_SIZE-1:0] exp_data [0:15];
  logic [DATA_SIZE-1:0] exp_sum;
  logic                 exp_err;
  int                   exp_n;
  int                   base_idx;
  int                   wr_total = 0;

  // Every write must hit the next consecutive address with the next expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("execute_tracks_write_en", bus.execute, bus.write_en);
      if (bus.write_en === 1'b1) begin
        chk("write_expected", (wr_total - base_idx) < exp_n, 1);
        if ((wr_total - base_idx) < exp_n) begin
          chk("write_addr", bus.current_addr, wr_total - base_idx);
          chk("write_data", bus.in_data, exp_data[wr_total - base_idx]);
        end
        chk("rx_ready_in_write", bus.rx_ready, 0);
        chk("busy_in_write", busy, 1);
        wr_total <= wr_total + 1;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem;
    mem_clear = 1'b1;
    step;
    mem_clear = 1'b0;
  endtask

  task automatic set_stim(input logic [7:0] b0, b1, b2, b3, b4, b5);
    stim[0] = b0; stim[1] = b1; stim[2] = b2;
    stim[3] = b3; stim[4] = b4; stim[5] = b5;
  endtask

  task automatic set_expect(input logic [15:0] trailer);
    exp_sum = '0;
    for (int w = 0; w < PROGRAM_SIZE; w++) begin
      exp_data[w] = DATA_SIZE'(stim[2*w]) + (DATA_SIZE'(stim[2*w+1]) << 8);
      exp_sum     = exp_sum + exp_data[w];
    end
    exp_err  = VERIFY && (trailer != exp_sum);
    exp_n    = PROGRAM_SIZE;
    base_idx = wr_total;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, output bit ok);
    int  n;
    bit  acc;
    if (gap) begin
      bus.rx_valid = 1'b0;
      step;
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.rx_valid = 1'b0;
    ok = acc;
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      step;
      n++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic run_load(input bit gap, input logic [15:0] trailer, input bit mid_start);
    bit ok;
    set_expect(trailer);
    start = 1'b1;
    step;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    for (int i = 0; i < 2*PROGRAM_SIZE; i++) begin
      send_byte(stim[i], gap, ok);
      chk("byte_accepted", ok, 1);
      if (i % 2 == 1) chk("write_latency", bus.write_en, 1);
      if (mid_start && i == 1) begin
        step;
        start = 1'b1;
        step;
        start = 1'b0;
        chk("start_ignored_words", words_written, 1);
        chk("start_ignored_addr", bus.current_addr, 1);
        chk("start_ignored_busy", busy, 1);
      end
    end
`ifdef MEM_LOADER_VERIFY_EN
    send_byte(trailer[7:0], gap, ok);
    chk("trailer_lo_accepted", ok, 1);
    send_byte(trailer[15:8], gap, ok);
    chk("trailer_hi_accepted", ok, 1);
`else
    step;
    chk("done_after_last_write", done, 1);
`endif
    wait_done;
    chk("busy_after_done", busy, 0);
    chk("words_written", words_written, PROGRAM_SIZE);
    chk("write_count", wr_total - base_idx, PROGRAM_SIZE);
    chk("error", error, exp_err);
  endtask

  initial begin
    bit ok;
    rst_n        = 1'b0;
    start        = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    mem_clear    = 1'b1;
    step;
    step;
    chk("rst_rx_ready", bus.rx_ready, 0);
    chk("rst_write_en", bus.write_en, 0);
    chk("rst_execute", bus.execute, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_addr", bus.current_addr, 0);
    chk("rst_in_data", bus.in_data, 0);
    chk("rst_words", words_written, 0);
    rst_n        = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    mem_clear    = 1'b0;
    step;
    chk("idle_busy", busy, 0);
    chk("idle_words", words_written, 0);

    set_stim(8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A);
    run_load(1'b0, 16'h0368, 1'b0);
    chk("model_sum", exp_sum, 16'h0368);
    chk("basic_mem0", mem[0], 24'h001234);
    chk("basic_mem1", mem[1], 24'h005678);
    chk("basic_mem2", mem[2], 24'h009ABC);

    clear_mem;
    run_load(1'b1, 16'h0368, 1'b0);
    chk("bp_mem0", mem[0], 24'h001234);
    chk("bp_mem1", mem[1], 24'h005678);
    chk("bp_mem2", mem[2], 24'h009ABC);

    run_load(1'b0, 16'h0000, 1'b0);
    chk("bad_csum_error", error, VERIFY ? 1 : 0);
    chk("bad_csum_done", done, 1);

    clear_mem;
    exp_n       = 1;
    exp_data[0] = 16'h1234;
    base_idx    = wr_total;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_byte(stim[i], 1'b0, ok);
      chk("mid_byte_accepted", ok, 1);
    end
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_words", words_written, 0);
    chk("mid_addr", bus.current_addr, 0);
    chk("mid_rx_ready", bus.rx_ready, 0);
    chk("mid_in_data", bus.in_data, 0);
    chk("mid_write_count", wr_total - base_idx, 1);
    chk("mid_mem0_kept", mem[0], 24'h001234);
    chk("mid_mem1_empty", mem[1], 24'h000000);

    set_stim(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    run_load(1'b0, 16'hCC99, 1'b0);
    chk("reload_sum", exp_sum, 16'hCC99);
    chk("reload_mem0", mem[0], 24'h002211);
    chk("reload_mem2", mem[2], 24'h006655);

    set_stim(8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A);
    run_load(1'b0, 16'h0368, 1'b1);
    chk("busy_start_mem1", mem[1], 24'h005678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Program loader that drives the write side of the instruction memory. It accepts a little-endian byte stream over a valid/ready handshake and assembles the bytes into DATA_SIZE-bit words. Each word is written to consecutive memory addresses starting at 0 with a one-cycle write_en/execute pulse. Optionally, it then reads the program back and checks it against a host-supplied checksum. It sits between the host/debug byte link and the memory port, and owns that port while busy.

## Interface
- INSTR_SIZE, 24: memory word width; must be greater than DATA_SIZE.
- DATA_SIZE, 16: payload bits per word; must be a multiple of 8.
- ADDR_SIZE, 8: memory address width.
- PROGRAM_SIZE, 16: words per load; 1 ≤ PROGRAM_SIZE ≤ 2**ADDR_SIZE.
- clk  in  1  the single clock; all logic on its rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- start  in  1  one-cycle request to begin a load.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- current_addr  out  ADDR_SIZE  memory address.
- in_data  out  DATA_SIZE  memory write data.
- write_en  out  1  memory write enable.
- execute  out  1  memory execute qualifier; a write happens only when write_en and execute are both high.
- out_data  in  INSTR_SIZE  combinational memory read data for current_addr.
- busy  out  1  a load is in progress.
- done  out  1  sticky; the last load completed.
- error  out  1  sticky; verify mismatch (always 0 when verify is compiled out).
- words_written  out  ADDR_SIZE+1  count of words written in the current or last load.

## Operation
- States: IDLE, COLLECT, WRITE, CSUM, VERIFY, CHECK.
  - CSUM, VERIFY and CHECK exist only when the verify feature is compiled in.
- BYTES = DATA_SIZE/8.
- A byte is accepted when rx_valid and rx_ready are both high at a rising edge.
- IDLE:
  - start pulses → COLLECT.
  - On entry to COLLECT: clear done, error, words_written, current_addr and the byte counter.
  - start is ignored in every other state.
- COLLECT:
  - rx_ready=1.
  - The k-th accepted byte (k=0..BYTES-1) fills word bits [8k+7:8k].
  - After byte BYTES-1 is accepted → WRITE.
- WRITE:
  - Lasts exactly one cycle.
  - write_en=1, execute=1, rx_ready=0; in_data holds the assembled word.
  - words_written increments.
  - If this is not the last word: current_addr increments, → COLLECT.
  - If this is the last word: → CSUM when verify is compiled in, otherwise → IDLE with done=1.
- Memory zero-extends the payload: each location holds {zeros, in_data}.
- write_en and execute are 0 in every state other than WRITE.
- Reset mid-operation:
  - The loader returns to IDLE with all outputs at reset values.
  - Locations already written keep their contents.
  - A partially assembled word is discarded.
- While busy, current_addr belongs to the loader. In IDLE, current_addr holds the last written address.

## Timing
- Reset values:
  - rx_ready, write_en, execute, busy, done, error: 0.
  - current_addr, in_data, words_written: 0.
- busy=1 from the cycle after start until the cycle done rises.
- Write latency: the memory write occurs on the edge ending the WRITE cycle, one cycle after the last byte of the word is accepted.
- Minimum time per word is BYTES+1 cycles. rx_valid gaps stretch COLLECT only; no bytes are dropped.
- Load with verify off: done rises the cycle after the final WRITE.

## Configuration
- Macro: MEM_LOADER_VERIFY_EN.
- Defined:
  - CSUM: accept a trailer of BYTES bytes, little-endian, holding the checksum = sum of all payload words mod 2**DATA_SIZE.
  - VERIFY: step current_addr from 0 to PROGRAM_SIZE-1, one address per cycle. Accumulate out_data[DATA_SIZE-1:0]. Flag a mismatch if out_data[INSTR_SIZE-1:DATA_SIZE] is nonzero at any address.
  - CHECK: lasts one cycle. error = (sum ≠ trailer) or a mismatch flag was raised. Then done=1, → IDLE.
- Not defined:
  - No trailer bytes are consumed.
  - error is tied to 0.
  - The verify states and the accumulator are absent.

## Structure
- Package mem_loader_pkg holds:
  - the state enum;
  - BYTE_W = 8;
  - a function computing BYTES from DATA_SIZE.
- Sub-module byte_assembler:
  - packs bytes into a DATA_SIZE-bit word;
  - has a byte counter and a word_complete strobe;
  - is reused for the checksum trailer.

## Test plan
Parameters for all scenarios: INSTR_SIZE=24, DATA_SIZE=16, ADDR_SIZE=4, PROGRAM_SIZE=3.
- Reset check: hold rst_n=0 for 2 cycles → all outputs 0.
  - During reset, rx_valid=1 and start=1 are also driven; neither has any effect.
- Basic load: start, then bytes 34 12 78 56 BC 9A with no gaps.
  - mem[0]=0x001234, mem[1]=0x005678, mem[2]=0x009ABC.
  - Exactly 3 write_en pulses; words_written=3; done=1.
- Backpressure: same bytes with rx_valid toggling every cycle.
  - Identical memory contents.
  - rx_ready=0 during every WRITE cycle.
- Verify build, trailer 68 03 (checksum 0x0368) → done=1, error=0. Repeat with trailer 00 00 → done=1, error=1.
- Reset mid-load: drive rst_n=0 after 3 bytes.
  - Result: busy=0 and mem[0]=0x001234 retained.
  - A new start reloads from address 0.
- Pulse start while busy → no restart, no change in count.
